// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: RTL I2C target for the I2CMB bus-side harness.
// Open-drain only: sda_oe_o / scl_oe_o = 1 pulls the wire low.
// Optional feature macro: I2C_SLV_STRETCH_EN (clock stretching on reads when
// the read byte is late). Without it scl_oe_o never asserts and a late byte
// goes out as 8'hFF.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       scl_oe_o,
  output logic [7:0] wr_data_o,
  output logic       wr_valid_o,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  input  logic       rd_valid_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACKCHK, IGNORE
  } state_t;

  // synchronizers and edge history; reset high so an idle bus shows no edges
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [7:0] shift_q, shift_n;
  logic       rw_q, rw_n;
  logic       sda_oe_q, sda_oe_n;
  logic       scl_oe_q, scl_oe_n;
  logic [7:0] wr_data_q, wr_data_n;
  logic       wr_valid_q, wr_valid_n;
  logic       rd_pend_q, rd_pend_n;   // request outstanding (drives rd_req_o)
  logic       rd_have_q, rd_have_n;   // a read byte is latched and unused
  logic [7:0] rd_buf_q, rd_buf_n;
  logic       rd_take, enter_rd;
  logic       start_q, stop_q, busy_q;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

  assign rd_take = rd_pend_q & rd_valid_i;

  // bring bus lines into the clock domain and keep one cycle of history
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // bus condition pulses and busy window
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= start_det;
      stop_q  <= stop_det;
      if (start_det)     busy_q <= 1'b1;
      else if (stop_det) busy_q <= 1'b0;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      wr_data_q  <= 8'h00;
      wr_valid_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_have_q  <= 1'b0;
      rd_buf_q   <= 8'h00;
    end else begin
      state_q    <= state_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      rw_q       <= rw_n;
      sda_oe_q   <= sda_oe_n;
      scl_oe_q   <= scl_oe_n;
      wr_data_q  <= wr_data_n;
      wr_valid_q <= wr_valid_n;
      rd_pend_q  <= rd_pend_n;
      rd_have_q  <= rd_have_n;
      rd_buf_q   <= rd_buf_n;
    end
  end

  // next-state: bits sampled on SCL rise, SDA moved only right after SCL fall
  always_comb begin
    state_n    = state_q;
    bit_cnt_n  = bit_cnt_q;
    shift_n    = shift_q;
    rw_n       = rw_q;
    sda_oe_n   = sda_oe_q;
    scl_oe_n   = scl_oe_q;
    wr_data_n  = wr_data_q;
    wr_valid_n = 1'b0;
    rd_pend_n  = rd_pend_q & ~rd_valid_i;
    rd_have_n  = rd_have_q | rd_take;
    rd_buf_n   = rd_take ? rd_data_i : rd_buf_q;
    enter_rd   = 1'b0;

    case (state_q)
      ADDR: begin
        if (scl_rise) begin
          shift_n   = {shift_q[6:0], sda_s};
          bit_cnt_n = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_n    = sda_s;
            state_n = (shift_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
      end
      ADDR_ACK: begin
        // first fall starts the ACK slot; a read leaves on the ACK rise so
        // the user gets half an SCL period before bit7 is due
        if (scl_fall) begin
          if (!sda_oe_q) sda_oe_n = 1'b1;
          else begin
            sda_oe_n = 1'b0;
            state_n  = WR_DATA;
          end
        end else if (scl_rise && sda_oe_q && rw_q) begin
          state_n  = RD_LOAD;
          enter_rd = 1'b1;
        end
      end
      WR_DATA: begin
        if (scl_rise) begin
          shift_n   = {shift_q[6:0], sda_s};
          bit_cnt_n = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_n = WR_ACK;
        end
      end
      WR_ACK: begin
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_n   = 1'b1;
            wr_data_n  = shift_q;
            wr_valid_n = 1'b1;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = WR_DATA;
          end
        end
      end
      RD_LOAD: begin
        // act only at the fall that opens bit7 (or while stretching it)
        if (scl_fall || scl_oe_q) begin
          if (rd_have_q) begin
            shift_n   = rd_buf_q;
            sda_oe_n  = ~rd_buf_q[7];
            rd_have_n = 1'b0;
            bit_cnt_n = 3'd0;
            state_n   = RD_DATA;
          end else if (scl_fall) begin
`ifdef I2C_SLV_STRETCH_EN
            scl_oe_n  = 1'b1;
            sda_oe_n  = 1'b0;
`else
            // late byte: send all ones, request stays open for the next byte
            shift_n   = 8'hFF;
            sda_oe_n  = 1'b0;
            bit_cnt_n = 3'd0;
            state_n   = RD_DATA;
`endif
          end
        end
      end
      RD_DATA: begin
        // bit7 already on SDA; let SCL go one clk later
        scl_oe_n = 1'b0;
        if (scl_rise) bit_cnt_n = bit_cnt_q + 3'd1;
        else if (scl_fall) begin
          if (bit_cnt_q != 3'd0) begin
            shift_n  = {shift_q[6:0], 1'b1};
            sda_oe_n = ~shift_q[6];
          end else begin
            sda_oe_n = 1'b0;
            state_n  = RD_ACKCHK;
          end
        end
      end
      RD_ACKCHK: begin
        if (scl_rise) begin
          if (!sda_s) begin
            state_n  = RD_LOAD;
            enter_rd = 1'b1;
          end else state_n = IGNORE;
        end
      end
      default: ;
    endcase

    if (enter_rd && !rd_have_q && !rd_pend_q) rd_pend_n = 1'b1;

    // bus conditions override everything
    if (start_det || stop_det) begin
      state_n   = start_det ? ADDR : IDLE;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
      scl_oe_n  = 1'b0;
      rd_pend_n = 1'b0;
      rd_have_n = 1'b0;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign scl_oe_o   = scl_oe_q;
  assign wr_data_o  = wr_data_q;
  assign wr_valid_o = wr_valid_q;
  assign rd_req_o   = rd_pend_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = busy_q | stop_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: open-drain bus master model,
// read-byte responder and output event counters.
module tb_i2c_slave_responder;

  localparam time Q = 60ns;   // quarter SCL period (SCL = 24 clk)

  logic clk, rst_n;
  logic scl_m, sda_m, scl, sda;
  logic sda_oe_o, scl_oe_o, wr_valid_o, rd_req_o, rd_valid_i;
  logic start_o, stop_o, busy_o;
  logic [7:0] wr_data_o, rd_data_i;

  assign scl = scl_m & ~scl_oe_o;
  assign sda = sda_m & ~sda_oe_o;

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl), .sda_i(sda),
    .sda_oe_o(sda_oe_o), .scl_oe_o(scl_oe_o),
    .wr_data_o(wr_data_o), .wr_valid_o(wr_valid_o),
    .rd_req_o(rd_req_o), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
    .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5ns clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // output event counters, sampled on the falling clock edge
  int wr_cycles = 0, start_cycles = 0, stop_cycles = 0;
  int sda_oe_cycles = 0, scl_oe_cycles = 0, hs_cnt = 0, busy_low = 0;
  logic [7:0] wr_log [0:15];
  logic busy_watch = 1'b0;

  always @(negedge clk) begin
    if (wr_valid_o) begin
      wr_log[wr_cycles[3:0]] <= wr_data_o;
      wr_cycles <= wr_cycles + 1;
    end
    if (start_o)                start_cycles  <= start_cycles + 1;
    if (stop_o)                 stop_cycles   <= stop_cycles + 1;
    if (sda_oe_o)               sda_oe_cycles <= sda_oe_cycles + 1;
    if (scl_oe_o)               scl_oe_cycles <= scl_oe_cycles + 1;
    if (rd_req_o && rd_valid_i) hs_cnt        <= hs_cnt + 1;
    if (busy_watch && !busy_o)  busy_low      <= busy_low + 1;
  end

  // read-byte supplier: answers rd_req_o after rd_wait clocks
  logic [7:0] rd_q [0:3];
  int rd_idx = 0, rd_wait = 0;

  initial begin
    rd_valid_i = 1'b0;
    rd_data_i  = 8'h00;
    forever begin
      @(posedge clk); #2ns;
      rd_valid_i = 1'b0;
      if (rd_req_o) begin
        if (rd_wait > 0) rd_wait--;
        else begin
          rd_data_i  = rd_q[rd_idx[1:0]];
          rd_idx++;
          rd_valid_i = 1'b1;
        end
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_scl_hi();
    int n = 0;
    while (scl !== 1'b1 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scl_timeout: SCL low for %0d clocks, limit 3000", n);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;    #Q;
    scl_m = 1'b1; wait_scl_hi(); #Q;
    r = sda;      #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; wait_scl_hi(); #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; wait_scl_hi(); #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_n);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack_n);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  initial begin
    logic a, r;
    logic [7:0] d;
    int b_wr, b_st, b_sp, b_oe, b_hs, b_so;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_sda_oe", sda_oe_o, 1'b0);
    chk1("rst_scl_oe", scl_oe_o, 1'b0);
    chk8("rst_wr_data", wr_data_o, 8'h00);
    chk1("rst_wr_valid", wr_valid_o, 1'b0);
    chk1("rst_rd_req", rd_req_o, 1'b0);
    chk1("rst_start", start_o, 1'b0);
    chk1("rst_stop", stop_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: write A5, 3C to 0x22
    b_wr = wr_cycles; b_st = start_cycles; b_sp = stop_cycles;
    i2c_start();
    chk1("t1_busy", busy_o, 1'b1);
    write_byte(8'h44, a); chk1("t1_addr_ack", a, 1'b0);
    write_byte(8'hA5, a); chk1("t1_b0_ack", a, 1'b0);
    write_byte(8'h3C, a); chk1("t1_b1_ack", a, 1'b0);
    i2c_stop();
    chkn("t1_wr_pulses", wr_cycles - b_wr, 2);
    chk8("t1_wr0", wr_log[b_wr[3:0]], 8'hA5);
    chk8("t1_wr1", wr_log[4'(b_wr + 1)], 8'h3C);
    chkn("t1_start", start_cycles - b_st, 1);
    chkn("t1_stop", stop_cycles - b_sp, 1);
    chk1("t1_busy_end", busy_o, 1'b0);

    // 2: read 96 (ACK), 0F (NACK), then the target must stay off the bus
    rd_q[0] = 8'h96; rd_q[1] = 8'h0F; rd_idx = 0; rd_wait = 0;
    b_hs = hs_cnt;
    i2c_start();
    write_byte(8'h45, a); chk1("t2_addr_ack", a, 1'b0);
    read_byte(1'b0, d);   chk8("t2_rd0", d, 8'h96);
    read_byte(1'b1, d);   chk8("t2_rd1", d, 8'h0F);
    b_oe = sda_oe_cycles;
    read_byte(1'b1, d);   chk8("t2_ignored", d, 8'hFF);
    chkn("t2_no_drive", sda_oe_cycles - b_oe, 0);
    chk1("t2_no_req", rd_req_o, 1'b0);
    i2c_stop();
    chkn("t2_handshakes", hs_cnt - b_hs, 2);

    // 3: foreign address 0x23
    b_wr = wr_cycles; b_st = start_cycles; b_sp = stop_cycles; b_oe = sda_oe_cycles;
    i2c_start();
    write_byte(8'h46, a); chk1("t3_addr_nack", a, 1'b1);
    write_byte(8'h55, a); chk1("t3_data_nack", a, 1'b1);
    i2c_stop();
    chkn("t3_no_drive", sda_oe_cycles - b_oe, 0);
    chkn("t3_no_wr", wr_cycles - b_wr, 0);
    chkn("t3_start", start_cycles - b_st, 1);
    chkn("t3_stop", stop_cycles - b_sp, 1);

    // 4: write 11, repeated START, read one byte
    rd_q[0] = 8'hC3; rd_idx = 0;
    b_st = start_cycles; b_hs = hs_cnt; b_wr = busy_low;
    i2c_start();
    busy_watch = 1'b1;
    write_byte(8'h44, a); chk1("t4_addr_ack", a, 1'b0);
    write_byte(8'h11, a); chk1("t4_data_ack", a, 1'b0);
    i2c_start();
    write_byte(8'h45, a); chk1("t4_raddr_ack", a, 1'b0);
    read_byte(1'b1, d);   chk8("t4_rd", d, 8'hC3);
    busy_watch = 1'b0;
    i2c_stop();
    chkn("t4_start", start_cycles - b_st, 2);
    chkn("t4_busy_gap", busy_low - b_wr, 0);
    chk8("t4_wr_data", wr_data_o, 8'h11);
    chkn("t4_handshake", hs_cnt - b_hs, 1);

    // 5: read byte arrives late
    rd_q[0] = 8'h5A; rd_idx = 0; rd_wait = 960;
    b_so = scl_oe_cycles;
    i2c_start();
    write_byte(8'h45, a); chk1("t5_addr_ack", a, 1'b0);
    read_byte(1'b1, d);
`ifdef I2C_SLV_STRETCH_EN
    chk8("t5_rd_stretched", d, 8'h5A);
    chk1("t5_scl_held", (scl_oe_cycles - b_so) > 0, 1'b1);
`else
    chk8("t5_rd_default", d, 8'hFF);
    chkn("t5_no_stretch", scl_oe_cycles - b_so, 0);
    chk1("t5_req_open", rd_req_o, 1'b1);
`endif
    i2c_stop();
    chk1("t5_req_closed", rd_req_o, 1'b0);
    rd_wait = 0;

    // 6: reset while the ACK of byte 3 is on the bus
    i2c_start();
    write_byte(8'h44, a); chk1("t6_addr_ack", a, 1'b0);
    write_byte(8'h01, a); chk1("t6_b0_ack", a, 1'b0);
    write_byte(8'h02, a); chk1("t6_b1_ack", a, 1'b0);
    for (int i = 7; i >= 0; i--) bit_xfer(i[0], r);
    chk1("t6_ack_driven", sda_oe_o, 1'b1);
    rst_n = 1'b0;
    #1ns;
    chk1("t6_async_release", sda_oe_o, 1'b0);
    chk8("t6_rst_wr_data", wr_data_o, 8'h00);
    chk1("t6_rst_busy", busy_o, 1'b0);
    #40ns;
    rst_n = 1'b1;
    bit_xfer(1'b1, r); chk1("t6_no_ack_after_rst", r, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte(8'h44, a); chk1("t6_re_addr_ack", a, 1'b0);
    write_byte(8'h77, a); chk1("t6_re_data_ack", a, 1'b0);
    i2c_stop();
    chk8("t6_re_wr_data", wr_data_o, 8'h77);
    chk1("t6_idle_busy", busy_o, 1'b0);

`ifndef I2C_SLV_STRETCH_EN
    chkn("scl_never_pulled", scl_oe_cycles, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
